// File: rtl/bcd_tick_counter_pkg.sv
// ---------------------------------------------------------------------------
// bcd_tick_counter_pkg
// Shared definitions for the BCD tick counter and its display decoder:
//   - state_t      : two-state run/pause FSM encoding
//   - DIGIT_W      : width of one BCD digit
//   - SEG7_TABLE   : active-low seven-segment patterns for 0..9 (bit0=a..bit6=g)
//   - SEG7_BLANK   : all segments off
// ---------------------------------------------------------------------------
package bcd_tick_counter_pkg;

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // Index 0 is the rightmost element of the concatenation.
    localparam logic [9:0][6:0] SEG7_TABLE = {
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/bcd_tick_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_tick_counter_if
// Groups the counter's control inputs and display/status outputs.
//   tick_in, run, clear         : driven by the master (board / bench)
//   ones, tens, hex0, hex1,
//   tick_seen, wrap             : driven by the slave (bcd_tick_counter)
// ---------------------------------------------------------------------------
interface bcd_tick_counter_if;
    import bcd_tick_counter_pkg::*;

    logic               tick_in;
    logic               run;
    logic               clear;
    logic [DIGIT_W-1:0] ones;
    logic [DIGIT_W-1:0] tens;
    logic [6:0]         hex0;
    logic [6:0]         hex1;
    logic               tick_seen;
    logic               wrap;

    modport master (
        output tick_in, run, clear,
        input  ones, tens, hex0, hex1, tick_seen, wrap
    );

    modport slave (
        input  tick_in, run, clear,
        output ones, tens, hex0, hex1, tick_seen, wrap
    );

endinterface

// File: rtl/bcd_tick_counter_seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Purely combinational BCD to active-low seven-segment decoder.
//   i_bcd : 4-bit BCD digit
//   o_seg : segments, bit0=a..bit6=g, 0 = lit; non-BCD codes show blank
// ---------------------------------------------------------------------------
module seg7_decode
    import bcd_tick_counter_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_bcd,
    output logic [6:0]         o_seg
);

    always_comb begin
        o_seg = SEG7_BLANK;
        if (i_bcd <= 4'd9) begin
            o_seg = SEG7_TABLE[i_bcd];
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// ---------------------------------------------------------------------------
// bcd_tick_counter
// Counts rising edges of an asynchronous divided clock on a two-digit BCD
// counter (COUNT_MIN..COUNT_MAX, wrapping) and drives two active-low
// seven-segment digits.
//   clk      : board clock, posedge only
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of bcd_tick_counter_if
//              (tick_in/run/clear in; ones/tens/hex0/hex1/tick_seen/wrap out)
// ---------------------------------------------------------------------------
module bcd_tick_counter
    import bcd_tick_counter_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int COUNT_MIN     = 1,
    parameter int COUNT_MAX     = 99,
    parameter int BLANK_LEADING = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    bcd_tick_counter_if.slave  bus
);

    localparam logic [DIGIT_W-1:0] MIN_ONES = DIGIT_W'(COUNT_MIN % 10);
    localparam logic [DIGIT_W-1:0] MIN_TENS = DIGIT_W'(COUNT_MIN / 10);
    localparam logic [DIGIT_W-1:0] MAX_ONES = DIGIT_W'(COUNT_MAX % 10);
    localparam logic [DIGIT_W-1:0] MAX_TENS = DIGIT_W'(COUNT_MAX / 10);

    localparam logic [6:0] RST_HEX0 = SEG7_TABLE[MIN_ONES];
    localparam logic [6:0] RST_HEX1 = ((BLANK_LEADING != 0) && (MIN_TENS == '0))
                                      ? SEG7_BLANK : SEG7_TABLE[MIN_TENS];

    // ---------------- synchronizer + edge history ----------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_edge;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync[gi] <= 1'b0;
                end else if (gi == 0) begin
                    r_sync[gi] <= bus.tick_in;
                end else begin
                    r_sync[gi] <= r_sync[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist <= 1'b0;
        end else begin
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    // Rising edges only: one count per full tick_in period.
    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

    // ---------------- FSM + count ----------------
    state_t             r_state;
    state_t             w_state_next;
    logic [DIGIT_W-1:0] r_ones;
    logic [DIGIT_W-1:0] r_tens;
    logic [DIGIT_W-1:0] w_ones_next;
    logic [DIGIT_W-1:0] w_tens_next;
    logic               r_tick_seen;
    logic               r_wrap;
    logic               w_tick_next;
    logic               w_wrap_next;

    always_comb begin
        w_state_next = bus.run ? RUNNING : PAUSED;
        w_ones_next  = r_ones;
        w_tens_next  = r_tens;
        w_tick_next  = 1'b0;
        w_wrap_next  = 1'b0;
        // clear beats an edge in the same cycle and never pulses tick_seen.
        if (bus.clear) begin
            w_ones_next = MIN_ONES;
            w_tens_next = MIN_TENS;
        end else if ((r_state == RUNNING) && w_edge) begin
            w_tick_next = 1'b1;
            if ((r_tens == MAX_TENS) && (r_ones == MAX_ONES)) begin
                w_ones_next = MIN_ONES;
                w_tens_next = MIN_TENS;
                w_wrap_next = 1'b1;
            end else if (r_ones < 4'd9) begin
                w_ones_next = r_ones + 4'd1;
            end else begin
                w_ones_next = '0;
                w_tens_next = r_tens + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= PAUSED;
            r_ones      <= MIN_ONES;
            r_tens      <= MIN_TENS;
            r_tick_seen <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ones      <= w_ones_next;
            r_tens      <= w_tens_next;
            r_tick_seen <= w_tick_next;
            r_wrap      <= w_wrap_next;
        end
    end

    // ---------------- display ----------------
    logic [DIGIT_W-1:0] w_digit [2];
    logic [6:0]         w_seg   [2];
    logic [6:0]         r_hex0;
    logic [6:0]         r_hex1;

    assign w_digit[0] = r_ones;
    assign w_digit[1] = r_tens;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            seg7_decode u_dec (
                .i_bcd (w_digit[gi]),
                .o_seg (w_seg[gi])
            );
        end
    endgenerate

    // Display registers lag the count by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hex0 <= RST_HEX0;
            r_hex1 <= RST_HEX1;
        end else begin
            r_hex0 <= w_seg[0];
            r_hex1 <= ((BLANK_LEADING != 0) && (r_tens == '0)) ? SEG7_BLANK : w_seg[1];
        end
    end

    assign bus.ones      = r_ones;
    assign bus.tens      = r_tens;
    assign bus.hex0      = r_hex0;
    assign bus.hex1      = r_hex1;
    assign bus.tick_seen = r_tick_seen;
    assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_bcd_tick_counter.sv
module tb_bcd_tick_counter;
    import bcd_tick_counter_pkg::*;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   seen_a;
    int   wrap_a;
    int   wrap_b;

    bcd_tick_counter_if ifa ();
    bcd_tick_counter_if ifb ();

    bcd_tick_counter #(
        .SYNC_STAGES(2), .COUNT_MIN(1), .COUNT_MAX(99), .BLANK_LEADING(1)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
    );

    bcd_tick_counter #(
        .SYNC_STAGES(2), .COUNT_MIN(0), .COUNT_MAX(59), .BLANK_LEADING(0)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (ifa.tick_seen) seen_a++;
        if (ifa.wrap)      wrap_a++;
        if (ifb.wrap)      wrap_b++;
    end

    // One tick_in period on instance a; starts and ends on a negedge.
    task automatic pulse_a(input int hi, input int lo);
        ifa.tick_in = 1'b1;
        repeat (hi) @(negedge clk);
        ifa.tick_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic pulse_b(input int hi, input int lo);
        ifb.tick_in = 1'b1;
        repeat (hi) @(negedge clk);
        ifb.tick_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        ifa.tick_in = 0; ifa.run = 0; ifa.clear = 0;
        ifb.tick_in = 0; ifb.run = 0; ifb.clear = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if ({ifa.tens, ifa.ones} !== 8'h01) begin
            bad++; $display("FAIL reset_count got=%h want=01", {ifa.tens, ifa.ones});
        end
        total++;
        if (ifa.hex0 !== 7'h79 || ifa.hex1 !== 7'h7F) begin
            bad++; $display("FAIL reset_hex got=%h/%h want=79/7f", ifa.hex0, ifa.hex1);
        end
        total++;
        if (ifa.tick_seen !== 1'b0 || ifa.wrap !== 1'b0) begin
            bad++; $display("FAIL reset_pulses got=%b%b want=00", ifa.tick_seen, ifa.wrap);
        end
        total++;
        if ({ifb.tens, ifb.ones} !== 8'h00 || ifb.hex0 !== 7'h40 || ifb.hex1 !== 7'h40) begin
            bad++; $display("FAIL reset_b got=%h %h/%h want=00 40/40",
                            {ifb.tens, ifb.ones}, ifb.hex0, ifb.hex1);
        end
        $display("reset: count=%h hex=%h/%h", {ifa.tens, ifa.ones}, ifa.hex0, ifa.hex1);
    endtask

    task automatic test_count;
        int s0;
        ifa.run = 1'b1;
        repeat (2) @(negedge clk);
        s0 = seen_a;
        repeat (3) pulse_a(10, 10);
        total++;
        if ({ifa.tens, ifa.ones} !== 8'h04) begin
            bad++; $display("FAIL count3 got=%h want=04", {ifa.tens, ifa.ones});
        end
        total++;
        if (seen_a - s0 !== 3) begin
            bad++; $display("FAIL tick_pulses got=%0d want=3", seen_a - s0);
        end
        total++;
        if (ifa.hex0 !== 7'h19 || ifa.hex1 !== 7'h7F) begin
            bad++; $display("FAIL hex_after3 got=%h/%h want=19/7f", ifa.hex0, ifa.hex1);
        end
        $display("count: 3 periods -> %h", {ifa.tens, ifa.ones});
    endtask

    task automatic test_wrap;
        int w0;
        bit seen_coincide;
        repeat (94) pulse_a(4, 4);
        total++;
        if ({ifa.tens, ifa.ones} !== 8'h98) begin
            bad++; $display("FAIL preload got=%h want=98", {ifa.tens, ifa.ones});
        end
        w0 = wrap_a;
        pulse_a(4, 4);
        total++;
        if ({ifa.tens, ifa.ones} !== 8'h99 || wrap_a !== w0) begin
            bad++; $display("FAIL at_max got=%h wraps=%0d want=99 wraps=0",
                            {ifa.tens, ifa.ones}, wrap_a - w0);
        end
        seen_coincide = 1'b0;
        ifa.tick_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 3) ifa.tick_in = 1'b0;
            if (ifa.wrap) begin
                total++;
                if (ifa.tick_seen !== 1'b1 || {ifa.tens, ifa.ones} !== 8'h01) begin
                    bad++; $display("FAIL wrap_coincide got=%b %h want=1 01",
                                    ifa.tick_seen, {ifa.tens, ifa.ones});
                end
                seen_coincide = 1'b1;
            end
        end
        total++;
        if (wrap_a - w0 !== 1 || !seen_coincide) begin
            bad++; $display("FAIL wrap_pulses got=%0d want=1", wrap_a - w0);
        end
        total++;
        if ({ifa.tens, ifa.ones} !== 8'h01 || ifa.hex0 !== 7'h79 || ifa.hex1 !== 7'h7F) begin
            bad++; $display("FAIL after_wrap got=%h %h/%h want=01 79/7f",
                            {ifa.tens, ifa.ones}, ifa.hex0, ifa.hex1);
        end
        $display("wrap: 99 -> %h", {ifa.tens, ifa.ones});
    endtask

    task automatic test_pause;
        int s0;
        ifa.run = 1'b0;
        @(negedge clk);
        s0 = seen_a;
        repeat (5) pulse_a(4, 4);
        total++;
        if ({ifa.tens, ifa.ones} !== 8'h01 || seen_a !== s0) begin
            bad++; $display("FAIL paused got=%h ticks=%0d want=01 ticks=0",
                            {ifa.tens, ifa.ones}, seen_a - s0);
        end
        ifa.run = 1'b1;
        repeat (2) @(negedge clk);
        pulse_a(4, 4);
        total++;
        if ({ifa.tens, ifa.ones} !== 8'h02) begin
            bad++; $display("FAIL resume got=%h want=02", {ifa.tens, ifa.ones});
        end
        $display("pause: resumed count=%h", {ifa.tens, ifa.ones});
    endtask

    task automatic test_clear;
        int s0;
        int w0;
        repeat (40) pulse_a(4, 4);
        total++;
        if ({ifa.tens, ifa.ones} !== 8'h42) begin
            bad++; $display("FAIL preload42 got=%h want=42", {ifa.tens, ifa.ones});
        end
        s0 = seen_a;
        w0 = wrap_a;
        // Rise seen at edge k, detected in the cycle before edge k+2.
        ifa.tick_in = 1'b1;
        repeat (2) @(negedge clk);
        ifa.clear = 1'b1;
        @(negedge clk);
        ifa.clear = 1'b0;
        total++;
        if ({ifa.tens, ifa.ones} !== 8'h01 || ifa.tick_seen !== 1'b0 || ifa.wrap !== 1'b0) begin
            bad++; $display("FAIL clear_edge got=%h ts=%b wr=%b want=01 0 0",
                            {ifa.tens, ifa.ones}, ifa.tick_seen, ifa.wrap);
        end
        repeat (3) @(negedge clk);
        ifa.tick_in = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (seen_a !== s0 || wrap_a !== w0 || {ifa.tens, ifa.ones} !== 8'h01) begin
            bad++; $display("FAIL clear_nopulse got=%h ticks=%0d wraps=%0d want=01 0 0",
                            {ifa.tens, ifa.ones}, seen_a - s0, wrap_a - w0);
        end
        pulse_a(4, 4);
        total++;
        if ({ifa.tens, ifa.ones} !== 8'h02) begin
            bad++; $display("FAIL after_clear got=%h want=02", {ifa.tens, ifa.ones});
        end
        $display("clear: after next edge count=%h", {ifa.tens, ifa.ones});
    endtask

    task automatic test_async_reset;
        repeat (55) pulse_a(4, 4);
        total++;
        if ({ifa.tens, ifa.ones} !== 8'h57) begin
            bad++; $display("FAIL preload57 got=%h want=57", {ifa.tens, ifa.ones});
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({ifa.tens, ifa.ones} !== 8'h01 || ifa.hex0 !== 7'h79 || ifa.hex1 !== 7'h7F) begin
            bad++; $display("FAIL async_rst got=%h %h/%h want=01 79/7f",
                            {ifa.tens, ifa.ones}, ifa.hex0, ifa.hex1);
        end
        total++;
        if (u_dut_a.r_state !== PAUSED || ifa.tick_seen !== 1'b0 || ifa.wrap !== 1'b0) begin
            bad++; $display("FAIL async_rst_state got=%b %b%b want=0 00",
                            u_dut_a.r_state, ifa.tick_seen, ifa.wrap);
        end
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        repeat (2) @(negedge clk);
        pulse_a(4, 4);
        total++;
        if ({ifa.tens, ifa.ones} !== 8'h02) begin
            bad++; $display("FAIL post_rst got=%h want=02", {ifa.tens, ifa.ones});
        end
        $display("async reset: post-release count=%h", {ifa.tens, ifa.ones});
    endtask

    task automatic test_alt_params;
        int w0;
        int hexbad;
        w0 = wrap_b;
        hexbad = 0;
        ifb.run = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 59; i++) begin
            pulse_b(4, 4);
            if (ifb.tens == 4'd0 && ifb.hex1 !== 7'h40) hexbad++;
        end
        total++;
        if (hexbad != 0) begin
            bad++; $display("FAIL b_hex1_zero got=%0d_bad want=0 (hex1=%h)", hexbad, ifb.hex1);
        end
        total++;
        if ({ifb.tens, ifb.ones} !== 8'h59 || wrap_b !== w0) begin
            bad++; $display("FAIL b_at_max got=%h wraps=%0d want=59 0",
                            {ifb.tens, ifb.ones}, wrap_b - w0);
        end
        pulse_b(4, 4);
        total++;
        if ({ifb.tens, ifb.ones} !== 8'h00 || wrap_b - w0 !== 1) begin
            bad++; $display("FAIL b_wrap got=%h wraps=%0d want=00 1",
                            {ifb.tens, ifb.ones}, wrap_b - w0);
        end
        total++;
        if (ifb.hex0 !== 7'h40 || ifb.hex1 !== 7'h40) begin
            bad++; $display("FAIL b_hex got=%h/%h want=40/40", ifb.hex0, ifb.hex1);
        end
        $display("alt params: 60 edges -> %h", {ifb.tens, ifb.ones});
    endtask

    initial begin
        total = 0; bad = 0;
        seen_a = 0; wrap_a = 0; wrap_b = 0;
        reset_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_count();
        test_wrap();
        test_pause();
        test_clear();
        test_async_reset();
        test_alt_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
